// File: rtl/rvecc_decode_pipe.sv
// Two-stage SECDED (39,32) decode pipeline with valid/ready handshake,
// saturating error counters and first-error capture.
module rvecc_decode_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      din,
    input  logic [6:0]       ecc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      dout,
    output logic             single_err,
    output logic             double_err,
    output logic [6:0]       syndrome,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] sb_cnt,
    output logic [CNT_W-1:0] db_cnt,
    output logic             err_sticky,
    output logic [6:0]       cap_syndrome,
    output logic [31:0]      cap_data
);

    // Codeword position of data bit j: j-th non-power-of-two position from 3.
    function automatic logic [5:0] data_pos(input int j);
        logic [5:0] pos;
        int         n;
        pos = '0;
        n   = 0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == j) pos = 6'(p);
                n++;
            end
        end
        return pos;
    endfunction

    function automatic logic [5:0] calc_ecc(input logic [31:0] d);
        logic [5:0] e;
        e = '0;
        for (int j = 0; j < 32; j++) begin
            if (d[j]) e = e ^ data_pos(j);
        end
        return e;
    endfunction

    // Check-bit and out-of-range syndromes match no data position, so they flip nothing.
    function automatic logic [31:0] flip_mask(input logic [5:0] s);
        logic [31:0] m;
        m = '0;
        for (int j = 0; j < 32; j++) begin
            m[j] = (data_pos(j) == s);
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic             r_vld_p1;
    logic [31:0]      r_din_p1;
    logic [5:0]       r_syn_p1;
    logic             r_par_p1;

    logic             r_vld_p2;
    logic [31:0]      r_dout_p2;
    logic             r_se_p2;
    logic             r_de_p2;
    logic [6:0]       r_syn_p2;

    logic [CNT_W-1:0] r_sb_cnt;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_sticky;
    logic [6:0]       r_cap_syn;
    logic [31:0]      r_cap_data;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_single;
    logic             w_double;
    logic [31:0]      w_corr;
    logic             w_load;

    assign w_adv2   = ~r_vld_p2 | out_ready;
    assign w_adv1   = ~r_vld_p1 | w_adv2;
    assign in_ready = w_adv1;
    assign w_load   = w_adv2 & r_vld_p1;

    always_comb begin
        w_single = r_par_p1 && (r_syn_p1 < 6'd39);
        w_double = (r_par_p1 && (r_syn_p1 >= 6'd39)) || (!r_par_p1 && (r_syn_p1 != 6'd0));
        w_corr   = r_din_p1 ^ (w_single ? flip_mask(r_syn_p1) : 32'd0);
    end

    // Stage 1: register raw word, Hamming syndrome and overall parity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_din_p1 <= '0;
            r_syn_p1 <= '0;
            r_par_p1 <= 1'b0;
        end else if (w_adv1) begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_din_p1 <= din;
                r_syn_p1 <= calc_ecc(din) ^ ecc_in[5:0];
                r_par_p1 <= ^{din, ecc_in};
            end
        end
    end

    // Stage 2: corrected data and classification flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_dout_p2 <= '0;
            r_se_p2   <= 1'b0;
            r_de_p2   <= 1'b0;
            r_syn_p2  <= '0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_dout_p2 <= w_corr;
                r_se_p2   <= w_single;
                r_de_p2   <= w_double;
                r_syn_p2  <= {r_par_p1, r_syn_p1};
            end
        end
    end

    // Statistics: events recorded as a transaction enters stage 2; clear wins
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            r_sb_cnt   <= '0;
            r_db_cnt   <= '0;
            r_sticky   <= 1'b0;
            r_cap_syn  <= '0;
            r_cap_data <= '0;
        end else if (w_load) begin
            if (w_single) r_sb_cnt <= sat_inc(r_sb_cnt);
            if (w_double) r_db_cnt <= sat_inc(r_db_cnt);
            if ((w_single || w_double) && !r_sticky) begin
                r_sticky   <= 1'b1;
                r_cap_syn  <= {r_par_p1, r_syn_p1};
                r_cap_data <= r_din_p1;
            end
        end
    end

    assign out_valid    = r_vld_p2;
    assign dout         = r_dout_p2;
    assign single_err   = r_se_p2;
    assign double_err   = r_de_p2;
    assign syndrome     = r_syn_p2;
    assign sb_cnt       = r_sb_cnt;
    assign db_cnt       = r_db_cnt;
    assign err_sticky   = r_sticky;
    assign cap_syndrome = r_cap_syn;
    assign cap_data     = r_cap_data;

endmodule

// File: doc/rvecc_decode_pipe.md
RVECC_DECODE_PIPE -- requirements
Module: rvecc_decode_pipe

Interface
- REQ-001: Parameter CNT_W, default 16; width of each saturating error counter.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  synchronous reset, active-high, sampled on clk rising edge.
- REQ-004: in_valid  input  1  codeword presented.
- REQ-005: in_ready  output  1  block accepts codeword this cycle.
- REQ-006: din  input  32  data word.
- REQ-007: ecc_in  input  7  check bits (SECDED, layout per REQ-012).
- REQ-008: out_valid  output  1  decoded result held on outputs.
- REQ-009: out_ready  input  1  consumer accepts result.
- REQ-010: dout  output  32  corrected data.
- REQ-011: single_err / double_err  output  1 each  result flags, qualified by out_valid.
- REQ-012: syndrome  output  7  {overall parity check, 6-bit Hamming syndrome}, qualified by out_valid.
- REQ-013: clr_stats  input  1  one-cycle pulse; clears counters, sticky flags and capture registers.
- REQ-014: sb_cnt / db_cnt  output  CNT_W each  saturating single-error / double-error counts.
- REQ-015: err_sticky  output  1  set on any error since reset/clear.
- REQ-016: cap_syndrome  output  7  syndrome of first error since reset/clear.
- REQ-017: cap_data  output  32  raw din of first error since reset/clear.

Function
- REQ-018: Codeword layout: data bit j occupies the j-th non-power-of-two position from 3 upward (d0=3, d1=5, d2=6, d3=7, d4=9 ... d26..d31=33..38).
- REQ-019: Check bits: ecc[i], i=0..5, is the XOR of data bits whose position has bit i set; ecc[6] is the XOR of din[31:0] and ecc[5:0].
- REQ-020: Stage 1 registers din, ecc_in and the syndrome S = recomputed ecc[5:0] XOR ecc_in[5:0], plus P = XOR of din and all seven ecc_in bits.
- REQ-021: Stage 2 registers corrected data and flags; transaction latency is exactly 2 cycles from accepted input to out_valid when there is no stall.
- REQ-022: S=0, P=0: no error; dout=din.
- REQ-023: P=1, S in {3,5,6,7,9..15,17..31,33..38}: single_err=1; flip the data bit at position S.
- REQ-024: P=1, S is 0 or a power of two (1,2,4,8,16,32): single_err=1; check-bit error; dout=din unchanged.
- REQ-025: P=1, S in 39..63: double_err=1, single_err=0; dout=din unchanged.
- REQ-026: P=0, S!=0: double_err=1; dout=din unchanged.
- REQ-027: single_err and double_err are never both 1.
- REQ-028: Stage 2 advances when ~out_valid | out_ready.
- REQ-029: Stage 1 advances when stage 1 is empty or stage 2 advances.
- REQ-030: in_ready equals the stage 1 advance condition; full throughput is 1 word/cycle.
- REQ-031: While out_valid=1 and out_ready=0, all outputs qualified by out_valid hold stable.
- REQ-032: Counters increment once per transaction, when it loads into stage 2; they saturate at 2^CNT_W-1 with no wrap.
- REQ-033: First error after reset/clear loads cap_syndrome/cap_data and sets err_sticky; later errors do not overwrite the capture.
- REQ-034: When clr_stats coincides with a stage-2 load: clear wins; counters=0, err_sticky=0, and that event is not recorded.
- REQ-035: clr_stats does not affect pipeline contents or handshake.

Reset
- REQ-036: On rst=1 at a clock edge: stage valids=0 (out_valid=0), sb_cnt=db_cnt=0, err_sticky=0, cap_syndrome=0, cap_data=0; dout/single_err/double_err/syndrome=0.
- REQ-037: Reset mid-transaction discards in-flight data with no output.
- REQ-038: in_ready=1 in the first cycle after reset deasserts.

Verification
- REQ-039: din=0x00000000, ecc_in=0x00 -> 2 cycles later out_valid=1, dout=0, no flags, syndrome=0x00.
- REQ-040: din=0x00000001, ecc_in=0x00 -> single_err=1, syndrome=0x43, dout=0x00000000, sb_cnt=1, cap_data=0x00000001.
- REQ-041: din=0x00000003, ecc_in=0x00 -> double_err=1, syndrome=0x06, dout=0x00000003, db_cnt=1.
- REQ-042: din=0, ecc_in=0x01 -> single_err=1, dout=0. Separately, din=0, ecc_in=0x40 -> single_err=1, syndrome=0x40, dout=0.
- REQ-043: Back-to-back stream of 8 words with out_ready held low for 3 cycles -> outputs stable while stalled, in_ready=0 once both stages are full, no loss or duplication, order preserved.
- REQ-044: CNT_W=2 with 5 single errors -> sb_cnt saturates at 3; clr_stats on the same cycle as an error load -> sb_cnt=0, err_sticky=0.
